// File: rtl/vending_money_accumulator_if.sv
// Button inputs and credit/status outputs of the vending money accumulator.
// master: panel side (drives buttons); slave: accumulator (drives credit/flags).
interface vending_money_accumulator_if;
    logic [2:0] coin_btn;
    logic [3:0] item_btn;
    logic       return_btn;
    logic [7:0] display_money_binary;
    logic [3:0] vend_item;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       coin_reject;
    logic       insufficient;
    logic       busy;

    modport master (
        output coin_btn, item_btn, return_btn,
        input  display_money_binary, vend_item, change_valid,
        input  change_amount, coin_reject, insufficient, busy
    );

    modport slave (
        input  coin_btn, item_btn, return_btn,
        output display_money_binary, vend_item, change_valid,
        output change_amount, coin_reject, insufficient, busy
    );
endinterface

// File: rtl/vending_money_accumulator.sv
// Vending front end: debounces buttons, keeps credit, vends and returns change.
// Ports: clk, rst (active-low sync), bus (slave: buttons in, credit/flags out).
module vending_money_accumulator #(
    parameter int DEB_TICK    = 50000,
    parameter int HOLD_CYCLES = 1000,
    parameter int MAX_MONEY   = 99,
    parameter int PRICE0      = 5,
    parameter int PRICE1      = 8,
    parameter int PRICE2      = 12,
    parameter int PRICE3      = 15
) (
    input  logic clk,
    input  logic rst,
    vending_money_accumulator_if.slave bus
);

    localparam int TW = $clog2(DEB_TICK);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(DEB_TICK - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [8:0]    MAX9      = 9'(MAX_MONEY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEND,
        S_RETURN
    } state_t;

    // Bit order: [7]=return, [6:3]=item, [2:0]=coin.
    logic [7:0]    raw;
    logic [7:0]    sync1;
    logic [7:0]    sync2;
    logic [7:0]    samp_prev;
    logic [7:0]    samp_cur;
    logic [7:0]    deb;
    logic [7:0]    deb_d;
    logic [7:0]    press;
    logic [TW-1:0] tick;

    assign raw   = {bus.return_btn, bus.item_btn, bus.coin_btn};
    assign press = deb & ~deb_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            samp_prev <= '0;
            samp_cur  <= '0;
            deb       <= '0;
            deb_d     <= '0;
            tick      <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Agreeing samples set the level; disagreeing ones keep it.
            deb   <= (samp_cur & samp_prev) | (deb & (samp_cur | samp_prev));
            deb_d <= deb;
            if (tick == TICK_LAST) begin
                tick      <= '0;
                samp_prev <= samp_cur;
                samp_cur  <= sync2;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

    logic       ev_ret;
    logic       ev_item;
    logic [1:0] item_idx;
    logic       ev_coin;
    logic [7:0] coin_val;
    logic [7:0] price;

    always_comb begin
        ev_ret   = 1'b0;
        ev_item  = 1'b0;
        item_idx = 2'd0;
        ev_coin  = 1'b0;
        coin_val = 8'd0;
        if (press[7]) begin
            ev_ret = 1'b1;
        end else if (|press[6:3]) begin
            ev_item = 1'b1;
            if (press[3])      item_idx = 2'd0;
            else if (press[4]) item_idx = 2'd1;
            else if (press[5]) item_idx = 2'd2;
            else               item_idx = 2'd3;
        end else if (|press[2:0]) begin
            ev_coin = 1'b1;
            if (press[0])      coin_val = 8'd1;
            else if (press[1]) coin_val = 8'd5;
            else               coin_val = 8'd10;
        end
    end

    always_comb begin
        price = 8'(PRICE0);
        unique case (item_idx)
            2'd0: price = 8'(PRICE0);
            2'd1: price = 8'(PRICE1);
            2'd2: price = 8'(PRICE2);
            2'd3: price = 8'(PRICE3);
            default: price = 8'(PRICE0);
        endcase
    end

    state_t        state;
    state_t        state_n;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_n;
    logic [7:0]    money;
    logic [7:0]    money_n;
    logic [3:0]    vend;
    logic [3:0]    vend_n;
    logic          chg_valid;
    logic          chg_valid_n;
    logic [7:0]    chg_amount;
    logic [7:0]    chg_amount_n;
    logic          reject;
    logic          reject_n;
    logic          short_credit;
    logic          short_credit_n;
    logic          busy_r;
    logic          busy_n;
    logic [8:0]    sum9;

    // Nine bits so a coin on top of high credit cannot wrap.
    assign sum9 = {1'b0, money} + {1'b0, coin_val};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            hold         <= '0;
            money        <= '0;
            vend         <= '0;
            chg_valid    <= 1'b0;
            chg_amount   <= '0;
            reject       <= 1'b0;
            short_credit <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state        <= state_n;
            hold         <= hold_n;
            money        <= money_n;
            vend         <= vend_n;
            chg_valid    <= chg_valid_n;
            chg_amount   <= chg_amount_n;
            reject       <= reject_n;
            short_credit <= short_credit_n;
            busy_r       <= busy_n;
        end
    end

    always_comb begin
        state_n        = state;
        hold_n         = hold;
        money_n        = money;
        vend_n         = vend;
        chg_valid_n    = 1'b0;
        chg_amount_n   = chg_amount;
        reject_n       = 1'b0;
        short_credit_n = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ev_ret) begin
                    chg_amount_n = money;
                    chg_valid_n  = 1'b1;
                    money_n      = '0;
                    hold_n       = '0;
                    state_n      = S_RETURN;
                end else if (ev_item) begin
                    if (money >= price) begin
                        money_n = money - price;
                        vend_n  = 4'b0001 << item_idx;
                        hold_n  = '0;
                        state_n = S_VEND;
                    end else begin
                        short_credit_n = 1'b1;
                    end
                end else if (ev_coin) begin
                    if (sum9 <= MAX9) money_n = sum9[7:0];
                    else              reject_n = 1'b1;
                end
            end
            S_VEND, S_RETURN: begin
                // Events arriving here are dropped on purpose.
                if (hold == HOLD_LAST) begin
                    state_n = S_IDLE;
                    vend_n  = '0;
                end else begin
                    hold_n = hold + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                vend_n  = '0;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    assign bus.display_money_binary = money;
    assign bus.vend_item            = vend;
    assign bus.change_valid         = chg_valid;
    assign bus.change_amount        = chg_amount;
    assign bus.coin_reject          = reject;
    assign bus.insufficient         = short_credit;
    assign bus.busy                 = busy_r;

endmodule

// File: tb/tb_vending_money_accumulator.sv
// Directed bench for vending_money_accumulator (DEB_TICK=4, HOLD_CYCLES=8).
// Each scenario task drives buttons and checks credit, flags and busy width.
module tb_vending_money_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] raw = '0;

    int n_cmp = 0;
    int n_bad = 0;

    vending_money_accumulator_if bus ();

    assign bus.coin_btn   = raw[2:0];
    assign bus.item_btn   = raw[6:3];
    assign bus.return_btn = raw[7];

    vending_money_accumulator #(
        .DEB_TICK    (4),
        .HOLD_CYCLES (8),
        .MAX_MONEY   (99),
        .PRICE0      (5),
        .PRICE1      (8),
        .PRICE2      (12),
        .PRICE3      (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cnt_cv   = 0;
    int cnt_rej  = 0;
    int cnt_ins  = 0;
    int cnt_busy = 0;
    int cnt_vend = 0;
    logic [3:0] last_vend = '0;

    always @(negedge clk) begin
        if (bus.change_valid) cnt_cv++;
        if (bus.coin_reject) cnt_rej++;
        if (bus.insufficient) cnt_ins++;
        if (bus.busy) cnt_busy++;
        if (bus.vend_item != 4'd0) begin
            cnt_vend++;
            last_vend = bus.vend_item;
        end
    end

    int b_cv, b_rej, b_ins, b_busy, b_vend;

    task automatic snap();
        b_cv   = cnt_cv;
        b_rej  = cnt_rej;
        b_ins  = cnt_ins;
        b_busy = cnt_busy;
        b_vend = cnt_vend;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bits: 0..2 coin, 3..6 item, 7 return.
    task automatic press(input int b);
        raw[b] = 1'b1;
        cyc(20);
        raw[b] = 1'b0;
        cyc(20);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc(3);
        n_cmp++;
        if ({bus.display_money_binary, bus.vend_item, bus.change_valid,
             bus.change_amount, bus.coin_reject, bus.insufficient,
             bus.busy} !== 24'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got money=%0d vend=%b cv=%b amt=%0d rej=%b ins=%b busy=%b, need all 0",
                     bus.display_money_binary, bus.vend_item, bus.change_valid,
                     bus.change_amount, bus.coin_reject, bus.insufficient, bus.busy);
        end
        rst = 1'b1;
        cyc(2);
    endtask

    task automatic test_coin_accumulate();
        snap();
        press(1);
        n_cmp++;
        if (bus.display_money_binary !== 8'd5) begin
            n_bad++;
            $display("FAIL coin_first: got %0d need 5", bus.display_money_binary);
        end
        press(1);
        n_cmp++;
        if (bus.display_money_binary !== 8'd10) begin
            n_bad++;
            $display("FAIL coin_second: got %0d need 10", bus.display_money_binary);
        end
        n_cmp++;
        if ((cnt_rej - b_rej) + (cnt_ins - b_ins) + (cnt_cv - b_cv) != 0) begin
            n_bad++;
            $display("FAIL coin_flags: got rej=%0d ins=%0d cv=%0d need 0",
                     cnt_rej - b_rej, cnt_ins - b_ins, cnt_cv - b_cv);
        end
    endtask

    task automatic test_vend();
        snap();
        raw[4] = 1'b1;
        cyc(4);
        // One sample period later: coin event lands inside VEND.
        raw[0] = 1'b1;
        cyc(20);
        raw[4] = 1'b0;
        raw[0] = 1'b0;
        cyc(20);
        n_cmp++;
        if (bus.display_money_binary !== 8'd2) begin
            n_bad++;
            $display("FAIL vend_money: got %0d need 2", bus.display_money_binary);
        end
        n_cmp++;
        if (last_vend !== 4'b0010) begin
            n_bad++;
            $display("FAIL vend_item: got %b need 0010", last_vend);
        end
        n_cmp++;
        if (cnt_busy - b_busy != 8) begin
            n_bad++;
            $display("FAIL vend_busy_len: got %0d need 8", cnt_busy - b_busy);
        end
        n_cmp++;
        if (cnt_vend - b_vend != 8) begin
            n_bad++;
            $display("FAIL vend_item_len: got %0d need 8", cnt_vend - b_vend);
        end
        n_cmp++;
        if (bus.vend_item !== 4'd0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL vend_exit: got vend=%b busy=%b need 0000/0",
                     bus.vend_item, bus.busy);
        end
    endtask

    task automatic test_insufficient();
        snap();
        press(3);
        n_cmp++;
        if (cnt_ins - b_ins != 1) begin
            n_bad++;
            $display("FAIL insuff_pulse: got %0d cycles need 1", cnt_ins - b_ins);
        end
        n_cmp++;
        if (bus.display_money_binary !== 8'd2 || cnt_busy != b_busy) begin
            n_bad++;
            $display("FAIL insuff_state: got money=%0d busy_cycles=%0d need 2/0",
                     bus.display_money_binary, cnt_busy - b_busy);
        end
        press(0);
        press(0);
        press(0);
        n_cmp++;
        if (bus.display_money_binary !== 8'd5) begin
            n_bad++;
            $display("FAIL refill_5: got %0d need 5", bus.display_money_binary);
        end
        snap();
        press(3);
        n_cmp++;
        if (bus.display_money_binary !== 8'd0 || last_vend !== 4'b0001) begin
            n_bad++;
            $display("FAIL exact_vend: got money=%0d vend=%b need 0/0001",
                     bus.display_money_binary, last_vend);
        end
        n_cmp++;
        if (cnt_ins != b_ins || cnt_busy - b_busy != 8) begin
            n_bad++;
            $display("FAIL exact_vend_flags: got ins=%0d busy=%0d need 0/8",
                     cnt_ins - b_ins, cnt_busy - b_busy);
        end
    endtask

    task automatic test_reject();
        for (int i = 0; i < 9; i++) press(2);
        press(1);
        n_cmp++;
        if (bus.display_money_binary !== 8'd95) begin
            n_bad++;
            $display("FAIL fill_95: got %0d need 95", bus.display_money_binary);
        end
        snap();
        press(2);
        n_cmp++;
        if (cnt_rej - b_rej != 1 || bus.display_money_binary !== 8'd95) begin
            n_bad++;
            $display("FAIL reject_10: got rej=%0d money=%0d need 1/95",
                     cnt_rej - b_rej, bus.display_money_binary);
        end
        press(1);
        press(1);
        n_cmp++;
        if (cnt_rej - b_rej != 3 || bus.display_money_binary !== 8'd95) begin
            n_bad++;
            $display("FAIL reject_5: got rej=%0d money=%0d need 3/95",
                     cnt_rej - b_rej, bus.display_money_binary);
        end
        for (int i = 0; i < 4; i++) press(0);
        n_cmp++;
        if (bus.display_money_binary !== 8'd99 || cnt_rej - b_rej != 3) begin
            n_bad++;
            $display("FAIL fill_99: got money=%0d rej=%0d need 99/3",
                     bus.display_money_binary, cnt_rej - b_rej);
        end
    endtask

    task automatic test_return();
        snap();
        press(7);
        n_cmp++;
        if (bus.change_amount !== 8'd99 || bus.display_money_binary !== 8'd0
            || cnt_cv - b_cv != 1) begin
            n_bad++;
            $display("FAIL return_99: got amt=%0d money=%0d cv=%0d need 99/0/1",
                     bus.change_amount, bus.display_money_binary, cnt_cv - b_cv);
        end
        press(2);
        press(2);
        press(2);
        press(1);
        press(0);
        press(0);
        n_cmp++;
        if (bus.display_money_binary !== 8'd37) begin
            n_bad++;
            $display("FAIL fill_37: got %0d need 37", bus.display_money_binary);
        end
        snap();
        raw[7] = 1'b1;
        raw[0] = 1'b1;
        cyc(20);
        raw[7] = 1'b0;
        raw[0] = 1'b0;
        cyc(20);
        n_cmp++;
        if (bus.change_amount !== 8'd37 || cnt_cv - b_cv != 1) begin
            n_bad++;
            $display("FAIL return_37: got amt=%0d cv=%0d need 37/1",
                     bus.change_amount, cnt_cv - b_cv);
        end
        n_cmp++;
        if (bus.display_money_binary !== 8'd0 || cnt_busy - b_busy != 8) begin
            n_bad++;
            $display("FAIL return_prio: got money=%0d busy=%0d need 0/8",
                     bus.display_money_binary, cnt_busy - b_busy);
        end
        snap();
        press(7);
        n_cmp++;
        if (bus.change_amount !== 8'd0 || cnt_cv - b_cv != 1) begin
            n_bad++;
            $display("FAIL return_zero: got amt=%0d cv=%0d need 0/1",
                     bus.change_amount, cnt_cv - b_cv);
        end
    endtask

    task automatic test_reset_mid_vend();
        int waited;
        press(1);
        raw[3] = 1'b1;
        waited = 0;
        while (bus.busy !== 1'b1 && waited < 40) begin
            cyc(1);
            waited++;
        end
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midvend_enter: busy=%b after %0d cycles need 1",
                     bus.busy, waited);
        end
        raw[3] = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        n_cmp++;
        if ({bus.display_money_binary, bus.vend_item, bus.change_valid,
             bus.change_amount, bus.coin_reject, bus.insufficient,
             bus.busy} !== 24'd0) begin
            n_bad++;
            $display("FAIL midvend_reset: got money=%0d vend=%b amt=%0d busy=%b need all 0",
                     bus.display_money_binary, bus.vend_item,
                     bus.change_amount, bus.busy);
        end
        rst = 1'b1;
        cyc(20);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.vend_item !== 4'd0
            || bus.display_money_binary !== 8'd0) begin
            n_bad++;
            $display("FAIL midvend_idle: got busy=%b vend=%b money=%0d need 0/0000/0",
                     bus.busy, bus.vend_item, bus.display_money_binary);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] m0;
        m0 = bus.display_money_binary;
        snap();
        for (int i = 0; i < 30; i++) begin
            raw[0] = ~raw[0];
            cyc(1);
        end
        raw[0] = 1'b0;
        cyc(30);
        n_cmp++;
        if (bus.display_money_binary !== m0
            && bus.display_money_binary !== m0 + 8'd1) begin
            n_bad++;
            $display("FAIL bounce: got %0d need %0d or %0d",
                     bus.display_money_binary, m0, m0 + 8'd1);
        end
        n_cmp++;
        if (cnt_rej != b_rej || cnt_ins != b_ins) begin
            n_bad++;
            $display("FAIL bounce_flags: got rej=%0d ins=%0d need 0/0",
                     cnt_rej - b_rej, cnt_ins - b_ins);
        end
    endtask

    initial begin
        test_reset();
        test_coin_accumulate();
        test_vend();
        test_insufficient();
        test_reject();
        test_return();
        test_reset_mid_vend();
        test_bounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
